// File: rtl/apb_timer_slave.sv
// apb_timer_slave: APB3 completer with a down-counting reload timer,
// sticky expiry status, scratch register and programmable wait states.
// Ports: PCLK, PRESET (sync, active-high); APB3 completer signals
// PSEL/PENABLE/PWRITE/PADDR/PWDATA in, PRDATA/PREADY/PSLVERR out;
// IRQ = INTSTAT[0] & CTRL[2] (level).
module apb_timer_slave #(
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 32,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [ADDR_WIDTH-1:0] PADDR,
   input  logic [DATA_WIDTH-1:0] PWDATA,
   output logic [DATA_WIDTH-1:0] PRDATA,
   output logic                  PREADY,
   output logic                  PSLVERR,
   output logic                  IRQ
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_WAIT,
      S_ACCESS
   } state_t;

   localparam int WL =
      (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
   localparam logic [3:0] WAIT_LAST = 4'(WL);
   localparam logic [DATA_WIDTH-1:0] ONE =
      DATA_WIDTH'(1);

   state_t                state;
   logic [3:0]            wcnt;

   // Transfer captured on ACCESS entry; the write
   // commits from these copies at the end of ACCESS,
   // so the master may already present the next setup.
   logic                  wr_q;
   logic [2:0]            off_q;
   logic [DATA_WIDTH-1:0] wdata_q;

   logic [2:0]            ctrl_q;
   logic [DATA_WIDTH-1:0] load_q;
   logic [DATA_WIDTH-1:0] value_q;
   logic [DATA_WIDTH-1:0] scratch_q;
   logic                  stat_q;

   logic [2:0]            off;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  acc_err;
   logic                  enter_acc;
   logic                  commit;
   logic                  expire;
   logic                  unused_paddr;

   assign off = PADDR[4:2];
   assign unused_paddr =
      ^{PADDR[ADDR_WIDTH-1:5], PADDR[1:0]};

   always_comb begin
      rd_data = '0;
      acc_err = 1'b0;
      unique case (1'b1)
         (off == 3'd0): rd_data[2:0] = ctrl_q;
         (off == 3'd1): rd_data = load_q;
         (off == 3'd2): begin
            rd_data = value_q;
            acc_err = PWRITE;
         end
         (off == 3'd3): rd_data[0] = stat_q;
         (off == 3'd4): rd_data = scratch_q;
         default:       acc_err = 1'b1;
      endcase
   end

   assign enter_acc = PSEL && (
      ((state == S_SETUP) && PENABLE &&
       (WAIT_CYCLES == 0)) ||
      ((state == S_WAIT) && (wcnt == WAIT_LAST)));

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state   <= S_IDLE;
         wcnt    <= '0;
         PREADY  <= 1'b0;
         PSLVERR <= 1'b0;
         PRDATA  <= '0;
         wr_q    <= 1'b0;
         off_q   <= '0;
         wdata_q <= '0;
      end else begin
         PREADY  <= enter_acc;
         PSLVERR <= enter_acc && acc_err;
         PRDATA  <= (enter_acc && !acc_err && !PWRITE)
                    ? rd_data : '0;
         if (enter_acc) begin
            wr_q    <= PWRITE;
            off_q   <= off;
            wdata_q <= PWDATA;
         end
         unique case (state)
            S_IDLE: begin
               if (PSEL && !PENABLE) state <= S_SETUP;
            end
            S_SETUP: begin
               wcnt <= '0;
               if (!PSEL) begin
                  state <= S_IDLE;
               end else if (PENABLE) begin
                  state <= (WAIT_CYCLES == 0)
                           ? S_ACCESS : S_WAIT;
               end
            end
            S_WAIT: begin
               if (!PSEL) begin
                  state <= S_IDLE;
               end else if (wcnt == WAIT_LAST) begin
                  state <= S_ACCESS;
               end else begin
                  wcnt <= wcnt + 4'd1;
               end
            end
            S_ACCESS: begin
               state <= (PSEL && !PENABLE)
                        ? S_SETUP : S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // PREADY is high exactly in ACCESS; an errored
   // transfer never commits.
   assign commit = PREADY && wr_q && !PSLVERR;
   assign expire = ctrl_q[0] && (value_q == '0);

   // Timer first, bus write last: a write overrides
   // the same-cycle decrement, reload or EN clear.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         ctrl_q    <= '0;
         load_q    <= '0;
         value_q   <= '0;
         scratch_q <= '0;
         stat_q    <= 1'b0;
      end else begin
         if (ctrl_q[0]) begin
            if (value_q != '0) begin
               value_q <= value_q - ONE;
            end else if (ctrl_q[1]) begin
               value_q <= load_q;
            end else begin
               ctrl_q[0] <= 1'b0;
            end
         end
         if (expire) begin
            stat_q <= 1'b1;
         end else if (commit && (off_q == 3'd3) &&
                      wdata_q[0]) begin
            stat_q <= 1'b0;
         end
         if (commit) begin
            unique case (1'b1)
               (off_q == 3'd0): ctrl_q <= wdata_q[2:0];
               (off_q == 3'd1): begin
                  load_q  <= wdata_q;
                  value_q <= wdata_q;
               end
               (off_q == 3'd4): scratch_q <= wdata_q;
               default: ;
            endcase
         end
      end
   end

   assign IRQ = stat_q & ctrl_q[2];

endmodule

// File: tb/tb_apb_timer_slave.sv
// tb_apb_timer_slave: self-checking bench for apb_timer_slave,
// one instance with no wait states and one with three.
module tb_apb_timer_slave;

   localparam logic [15:0] A_CTRL  = 16'h0000;
   localparam logic [15:0] A_LOAD  = 16'h0004;
   localparam logic [15:0] A_VALUE = 16'h0008;
   localparam logic [15:0] A_STAT  = 16'h000C;
   localparam logic [15:0] A_SCR   = 16'h0010;

   logic        clk;
   logic        rst;
   logic        psel0, psel3;
   logic        penable, pwrite;
   logic [15:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata0, prdata3;
   logic        pready0, pready3;
   logic        pslverr0, pslverr3;
   logic        irq0, irq3;

   int total;
   int bad;

   apb_timer_slave #(
      .ADDR_WIDTH(16), .DATA_WIDTH(32), .WAIT_CYCLES(0)
   ) u_dut0 (
      .PCLK(clk), .PRESET(rst), .PSEL(psel0),
      .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata),
      .PRDATA(prdata0), .PREADY(pready0),
      .PSLVERR(pslverr0), .IRQ(irq0)
   );

   apb_timer_slave #(
      .ADDR_WIDTH(16), .DATA_WIDTH(32), .WAIT_CYCLES(3)
   ) u_dut3 (
      .PCLK(clk), .PRESET(rst), .PSEL(psel3),
      .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata),
      .PRDATA(prdata3), .PREADY(pready3),
      .PSLVERR(pslverr3), .IRQ(irq3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit");
      $fatal(1, "watchdog");
   end

   // One APB transfer; returns at #1 after the completing edge.
   // lat = access-phase cycles seen with PREADY low.
   task automatic xfer(input bit s3, input bit wr,
                       input logic [15:0] a,
                       input logic [31:0] wd,
                       output logic [31:0] rd,
                       output logic er, output int lat);
      int n;
      if (s3) psel3 = 1'b1;
      else    psel0 = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = a;
      pwdata  = wd;
      @(posedge clk); #1;
      penable = 1'b1;
      n  = 0;
      rd = '0;
      er = 1'b0;
      while (!(s3 ? pready3 : pready0) && n < 64) begin
         @(posedge clk); #1;
         n++;
      end
      lat = n;
      if (n >= 64) begin
         total++;
         bad++;
         $display("FAIL xfer_timeout addr=%h", a);
      end else begin
         rd = s3 ? prdata3 : prdata0;
         er = s3 ? pslverr3 : pslverr0;
      end
      @(posedge clk); #1;
      psel0   = 1'b0;
      psel3   = 1'b0;
      penable = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      logic er;
      int lat;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({prdata0, pready0, pslverr0, irq0} !== '0) begin
         bad++;
         $display("FAIL reset_dut0 got=%h rdy=%b err=%b irq=%b exp=0",
                  prdata0, pready0, pslverr0, irq0);
      end
      total++;
      if ({prdata3, pready3, pslverr3, irq3} !== '0) begin
         bad++;
         $display("FAIL reset_dut3 got=%h rdy=%b err=%b irq=%b exp=0",
                  prdata3, pready3, pslverr3, irq3);
      end
      rst = 1'b0;
      xfer(1, 1, A_SCR, 32'h1111_2222, rd, er, lat);
      psel3   = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = A_SCR;
      pwdata  = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         total++;
         if ({prdata3, pready3, pslverr3, irq3} !== '0) begin
            bad++;
            $display("FAIL reset_mid got=%h rdy=%b err=%b exp=0",
                     prdata3, pready3, pslverr3);
         end
      end
      rst = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         total++;
         if (pready3 !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_ready got=%b exp=0", pready3);
         end
      end
      psel3   = 1'b0;
      penable = 1'b0;
      @(posedge clk); #1;
      xfer(1, 0, A_SCR, '0, rd, er, lat);
      total++;
      if (rd !== 32'h0 || er !== 1'b0) begin
         bad++;
         $display("FAIL reset_scratch got=%h err=%b exp=0",
                  rd, er);
      end
   endtask

   task automatic test_wait_states();
      logic [31:0] rd;
      logic er;
      int lat;
      xfer(1, 1, A_SCR, 32'hA5A5_1234, rd, er, lat);
      total++;
      if (lat != 4 || er !== 1'b0) begin
         bad++;
         $display("FAIL wait_write lat=%0d err=%b exp lat=4 err=0",
                  lat, er);
      end
      xfer(1, 0, A_SCR, '0, rd, er, lat);
      total++;
      if (lat != 4 || er !== 1'b0 || rd !== 32'hA5A5_1234) begin
         bad++;
         $display("FAIL wait_read lat=%0d err=%b got=%h exp 4/0/a5a51234",
                  lat, er, rd);
      end
      xfer(1, 0, 16'h0018, '0, rd, er, lat);
      total++;
      if (lat != 4 || er !== 1'b1 || rd !== 32'h0) begin
         bad++;
         $display("FAIL wait_err lat=%0d err=%b got=%h exp 4/1/0",
                  lat, er, rd);
      end
   endtask

   // Register file model indexed by offset; timer stays off.
   task automatic test_random_regs();
      logic [31:0] m [0:4];
      logic [31:0] rd, wd, exp_rd;
      logic [15:0] a;
      logic er, exp_er;
      bit wr;
      int lat, off;
      for (int i = 0; i < 5; i++) m[i] = '0;
      for (int it = 0; it < 40; it++) begin
         off = int'($urandom_range(0, 7));
         wr  = 1'($urandom_range(0, 1));
         a   = 16'($urandom);
         a[4:2] = 3'(off);
         wd  = $urandom;
         if (off == 0) wd[0] = 1'b0;
         exp_er = (off >= 5) || (wr && off == 2);
         exp_rd = (off < 5 && !exp_er) ? m[off] : 32'h0;
         xfer(0, wr, a, wd, rd, er, lat);
         total++;
         if (er !== exp_er || lat != 1) begin
            bad++;
            $display("FAIL rand_err a=%h wr=%b err=%b lat=%0d exp %b/1",
                     a, wr, er, lat, exp_er);
         end
         if (!wr) begin
            total++;
            if (rd !== exp_rd) begin
               bad++;
               $display("FAIL rand_read a=%h got=%h exp=%h",
                        a, rd, exp_rd);
            end
         end else if (!exp_er) begin
            if (off == 0) m[0] = wd & 32'h7;
            if (off == 1) begin
               m[1] = wd;
               m[2] = wd;
            end
            if (off == 4) m[4] = wd;
         end
      end
      total++;
      if (irq0 !== 1'b0) begin
         bad++;
         $display("FAIL rand_irq got=%b exp=0", irq0);
      end
   endtask

   task automatic test_errors();
      logic [31:0] rd;
      logic er;
      int lat;
      xfer(0, 0, 16'h0018, '0, rd, er, lat);
      total++;
      if (er !== 1'b1 || rd !== 32'h0) begin
         bad++;
         $display("FAIL err_read18 err=%b got=%h exp 1/0", er, rd);
      end
      xfer(0, 1, A_LOAD, 32'h0000_1234, rd, er, lat);
      xfer(0, 1, A_VALUE, 32'h55, rd, er, lat);
      total++;
      if (er !== 1'b1) begin
         bad++;
         $display("FAIL err_wr_value err=%b exp=1", er);
      end
      xfer(0, 0, A_VALUE, '0, rd, er, lat);
      total++;
      if (er !== 1'b0 || rd !== 32'h1234) begin
         bad++;
         $display("FAIL err_value_kept got=%h err=%b exp 1234/0",
                  rd, er);
      end
      xfer(0, 1, 16'h0014, 32'hFFFF_FFFF, rd, er, lat);
      total++;
      if (er !== 1'b1) begin
         bad++;
         $display("FAIL err_wr_unmapped err=%b exp=1", er);
      end
      xfer(0, 1, 16'hC010, 32'h77, rd, er, lat);
      xfer(0, 0, 16'h0013, '0, rd, er, lat);
      total++;
      if (er !== 1'b0 || rd !== 32'h77) begin
         bad++;
         $display("FAIL err_alias got=%h err=%b exp 77/0", rd, er);
      end
   endtask

   task automatic test_one_shot();
      logic [31:0] rd;
      logic er;
      int lat, n, ld;
      for (int it = 0; it < 4; it++) begin
         ld = (it == 0) ? 5 : int'($urandom_range(0, 12));
         xfer(0, 1, A_LOAD, 32'(ld), rd, er, lat);
         xfer(0, 1, A_CTRL, 32'h5, rd, er, lat);
         n = 0;
         while (!irq0 && n < 64) begin
            @(posedge clk); #1;
            n++;
         end
         total++;
         if (n != ld + 1) begin
            bad++;
            $display("FAIL oneshot_delay load=%0d got=%0d exp=%0d",
                     ld, n, ld + 1);
         end
         xfer(0, 0, A_CTRL, '0, rd, er, lat);
         total++;
         if (rd !== 32'h4) begin
            bad++;
            $display("FAIL oneshot_ctrl got=%h exp=4", rd);
         end
         xfer(0, 0, A_VALUE, '0, rd, er, lat);
         total++;
         if (rd !== 32'h0) begin
            bad++;
            $display("FAIL oneshot_value got=%h exp=0", rd);
         end
         xfer(0, 1, A_STAT, 32'h1, rd, er, lat);
         total++;
         if (irq0 !== 1'b0) begin
            bad++;
            $display("FAIL oneshot_w1c irq=%b exp=0", irq0);
         end
      end
   endtask

   task automatic test_auto_reload();
      logic [31:0] rd;
      logic er;
      int lat, n;
      xfer(0, 1, A_LOAD, 32'h2, rd, er, lat);
      xfer(0, 1, A_CTRL, 32'h7, rd, er, lat);
      n = 0;
      while (!irq0 && n < 64) begin
         @(posedge clk); #1;
         n++;
      end
      total++;
      if (n != 3) begin
         bad++;
         $display("FAIL reload_first got=%0d exp=3", n);
      end
      // Commit lands on the next expiry, three cycles on.
      xfer(0, 1, A_STAT, 32'h1, rd, er, lat);
      total++;
      if (irq0 !== 1'b1) begin
         bad++;
         $display("FAIL reload_set_wins irq=%b exp=1", irq0);
      end
      @(posedge clk); #1;
      xfer(0, 1, A_STAT, 32'h1, rd, er, lat);
      total++;
      if (irq0 !== 1'b0) begin
         bad++;
         $display("FAIL reload_clear irq=%b exp=0", irq0);
      end
      n = 0;
      while (!irq0 && n < 64) begin
         @(posedge clk); #1;
         n++;
      end
      total++;
      if (n != 2) begin
         bad++;
         $display("FAIL reload_period got=%0d exp=2", n);
      end
      xfer(0, 1, A_CTRL, 32'h0, rd, er, lat);
      xfer(0, 1, A_STAT, 32'h1, rd, er, lat);
      xfer(0, 0, A_STAT, '0, rd, er, lat);
      total++;
      if (rd !== 32'h0) begin
         bad++;
         $display("FAIL reload_stop stat=%h exp=0", rd);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd, v;
      logic er;
      int lat;
      v = $urandom;
      xfer(0, 1, A_CTRL, 32'h6, rd, er, lat);
      psel0   = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = A_SCR;
      pwdata  = v;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      total++;
      if (pready0 !== 1'b1 || pslverr0 !== 1'b0) begin
         bad++;
         $display("FAIL b2b_first rdy=%b err=%b exp 1/0",
                  pready0, pslverr0);
      end
      pwrite  = 1'b0;
      paddr   = A_CTRL;
      penable = 1'b0;
      @(posedge clk); #1;
      total++;
      if (pready0 !== 1'b0) begin
         bad++;
         $display("FAIL b2b_gap rdy=%b exp=0", pready0);
      end
      penable = 1'b1;
      @(posedge clk); #1;
      total++;
      if (pready0 !== 1'b1 || prdata0 !== 32'h6 ||
          pslverr0 !== 1'b0) begin
         bad++;
         $display("FAIL b2b_second rdy=%b got=%h err=%b exp 1/6/0",
                  pready0, prdata0, pslverr0);
      end
      @(posedge clk); #1;
      psel0   = 1'b0;
      penable = 1'b0;
      xfer(0, 0, A_SCR, '0, rd, er, lat);
      total++;
      if (rd !== v) begin
         bad++;
         $display("FAIL b2b_scratch got=%h exp=%h", rd, v);
      end
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      rst     = 1'b1;
      psel0   = 1'b0;
      psel3   = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = '0;
      pwdata  = '0;
      test_reset();
      test_wait_states();
      test_random_regs();
      test_errors();
      test_one_shot();
      test_auto_reload();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
